nrisc_mem_port_master: RTL and testbench
========================================

Name: nrisc_mem_port_master

Overview:
- Core-side initiator for one port of the shared data memory: accepts load/store requests from a core pipeline over valid/ready, drives the port's address/data/write/load lines, captures read data after a fixed latency, and returns one response per request.
- One instance per core; the instance for core k connects to dataADDRk/dataINk/dataOUTk and bit k of dataWrite/dataLoad.

Parameters:
- TAM, 16, data and request address width in bits.
- Lmem, 8, implemented memory address bits (2^Lmem words).
- MEM_LAT, 1, cycles from the edge that samples mem_load=1 to the edge where mem_dout is valid and captured (1..7).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  TAM  word address.
- req_wdata  in  TAM  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  TAM  load data (0 for stores and errors).
- rsp_we  out  1  echo of req_we for this response.
- rsp_err  out  1  address error; tied 0 unless ADDR_CHECK_EN is defined.
- mem_addr  out  TAM  to memory dataADDR; upper TAM-Lmem bits always 0.
- mem_din  out  TAM  to memory dataIN.
- mem_write  out  1  to memory dataWrite bit.
- mem_load  out  1  to memory dataLoad bit.
- mem_dout  in  TAM  from memory dataOUT.

Behaviour:
- Reset state and outputs: state = IDLE, req_ready = 1, rsp_valid = 0, and rsp_rdata, rsp_we, rsp_err, mem_addr, mem_din, mem_write, mem_load all 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state only; none is combinational from inputs.
- IDLE:
  - req_ready = 1.
  - On req_valid at a posedge: latch we, addr[Lmem-1:0], wdata; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched address; mem_din = latched wdata.
  - mem_write = we; mem_load = ~we.
  - Store: go to RESP with rsp_rdata = 0.
  - Load: go to WAIT with counter = MEM_LAT.
- WAIT:
  - mem_write = mem_load = 0; mem_addr is held.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0: rsp_rdata <= mem_dout; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata, rsp_we, rsp_err are held stable until handshake.
  - On rsp_ready at a posedge: go to IDLE. No new request is accepted in the same edge.
- req_ready = 0 in every state except IDLE.
- Latency, request accepted at edge T:
  - store: memory write occurs at edge T+1; rsp_valid is high from T+1.
  - load: rsp_valid is high from T+1+MEM_LAT.
- Addressing: req_addr bits above Lmem-1 are dropped, so addresses wrap modulo 2^Lmem (e.g. 0x1FF maps to 0xFF).
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely; no memory activity occurs meanwhile.
- Reset mid-operation: rst asserted in any state returns the block immediately to IDLE with reset outputs. mem_write/mem_load drop asynchronously, and any in-flight response is discarded.
- Within a state, req_* inputs are sampled only in IDLE; changes at any other time are ignored.

Optional Feature:
- Macro NRISC_MEM_ADDR_CHECK_EN.
- Defined: any req_addr with a nonzero bit above Lmem-1 is accepted normally, but ISSUE asserts neither mem_write nor mem_load. The block still passes through WAIT (if a load) with normal timing, then RESP with rsp_err = 1 and rsp_rdata = 0.
- Undefined: rsp_err is tied 0 and out-of-range addresses wrap as described above.

Test Plan:
- Reset: assert rst mid-WAIT (MEM_LAT=1) -> all outputs 0 and req_ready = 1 immediately; no rsp_valid follows.
- Store then load: store addr 0x0012, data 0xBEEF; load addr 0x0012 -> store response rsp_valid at T+1 with rsp_rdata 0 and rsp_we 1; load response rsp_rdata = 0xBEEF, rsp_valid at T+2.
- Latency sweep: MEM_LAT=3, load of pre-written 0x00A5 -> mem_load high for exactly 1 cycle; rsp_valid first seen at T+4 with 0x00A5.
- Backpressure: rsp_ready held 0 for 5 cycles after a load response -> rsp_valid and rsp_rdata stable, req_ready = 0, mem_write = mem_load = 0 throughout.
- Wrap: store 0x1234 to 0x01FF, then load 0x00FF -> 0x1234 (macro undefined).
- Macro defined: load from 0x0100 -> no mem_load pulse; rsp_err = 1, rsp_rdata = 0.

Source files
------------

// File: rtl/nrisc_mem_port_master_if.sv
// nrisc_mem_port_master_if
// Bundles the core-side request/response handshake and the memory-port lines
// of one nrisc_mem_port_master instance.
//   req_*  : load/store request from the core (valid/ready)
//   rsp_*  : one response per request back to the core (valid/ready)
//   mem_*  : address/data/write/load lines to one shared-memory port, and
//            the read data coming back (mem_dout)
// Modports:
//   master : the port-master block itself
//   slave  : the environment (core pipeline plus memory port)
interface nrisc_mem_port_master_if #(
  parameter int TAM = 16
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [TAM-1:0] req_addr;
  logic [TAM-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [TAM-1:0] rsp_rdata;
  logic           rsp_we;
  logic           rsp_err;
  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_din;
  logic           mem_write;
  logic           mem_load;
  logic [TAM-1:0] mem_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err,
           mem_addr, mem_din, mem_write, mem_load
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err,
           mem_addr, mem_din, mem_write, mem_load
  );
endinterface

// File: rtl/nrisc_mem_port_master.sv
// nrisc_mem_port_master
// Core-side initiator for one port of the shared data memory. Accepts one
// load/store request at a time, drives the memory port for exactly one cycle,
// waits MEM_LAT cycles for load data, then holds a response until the core
// takes it.
// Ports:
//   clk  : system clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   bus  : nrisc_mem_port_master_if.master (request, response, memory lines)
// Parameters:
//   TAM     : data/address width
//   Lmem    : implemented memory address bits (must be < TAM)
//   MEM_LAT : cycles from the load-sampling edge to the data-capture edge (1..7)
// Configuration macro:
//   NRISC_MEM_ADDR_CHECK_EN : when defined, requests with address bits set
//   above Lmem-1 suppress the memory access and answer with rsp_err = 1.
//   When undefined, those bits are dropped and addresses wrap.
module nrisc_mem_port_master #(
  parameter int TAM     = 16,
  parameter int Lmem    = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  nrisc_mem_port_master_if.master bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          nextState;
  logic            weReg;
  logic            errReg;
  logic [Lmem-1:0] addrReg;
  logic [TAM-1:0]  wdataReg;
  logic [TAM-1:0]  rdataReg;
  logic [CW-1:0]   waitCnt;
  logic            addrErr;

`ifdef NRISC_MEM_ADDR_CHECK_EN
  assign addrErr = |bus.req_addr[TAM-1:Lmem];
`else
  assign addrErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A store skips WAIT; a load (even an erroring one)
  // spends MEM_LAT cycles there so the response timing never depends on the
  // address.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (bus.req_valid) nextState = ISSUE;
      ISSUE: nextState = weReg ? RESP : WAIT;
      WAIT:  if (waitCnt == CW'(1)) nextState = RESP;
      RESP:  if (bus.rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, latency counter and read-data capture. The request is
  // only looked at in IDLE, so the core may change req_* freely afterwards.
  // The counter is loaded in ISSUE and the edge that takes it from 1 to 0 is
  // the one where memory data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weReg    <= 1'b0;
      errReg   <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
      waitCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            weReg    <= bus.req_we;
            errReg   <= addrErr;
            addrReg  <= bus.req_addr[Lmem-1:0];
            wdataReg <= bus.req_wdata;
          end
        end
        ISSUE: begin
          waitCnt <= CW'(MEM_LAT);
          if (weReg) rdataReg <= '0;
        end
        WAIT: begin
          waitCnt <= waitCnt - CW'(1);
          if (waitCnt == CW'(1)) rdataReg <= errReg ? '0 : bus.mem_dout;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state and registered request fields only, so the
  // strobes fall as soon as reset forces the state back to IDLE.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdataReg;
    bus.rsp_we    = weReg;
    bus.rsp_err   = errReg;
    bus.mem_addr  = {{(TAM-Lmem){1'b0}}, addrReg};
    bus.mem_din   = wdataReg;
    bus.mem_write = (state == ISSUE) &&  weReg && !errReg;
    bus.mem_load  = (state == ISSUE) && !weReg && !errReg;
  end

endmodule

// File: tb/tb_nrisc_mem_port_master.sv
// tb_nrisc_mem_port_master
// Two port masters side by side, one with MEM_LAT=1 and one with MEM_LAT=3,
// each attached to its own behavioural memory. Requests are checked against
// a word-array reference of what each memory should hold and the response
// latency the block promises.
module tb_nrisc_mem_port_master;

  localparam int TAM  = 16;
  localparam int LMEM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  logic [1:0]            reqValid, reqWe, rspReady;
  logic [1:0][TAM-1:0]   reqAddr, reqWdata;
  logic [1:0]            reqReady, rspValid, rspWe, rspErr, memWrite, memLoad;
  logic [1:0][TAM-1:0]   rspRdata, memAddr, memDin;
  logic [1:0][31:0]      loadCnt, writeCnt;

  logic [15:0] refMem [2][256];

  // One DUT plus latency-accurate memory per MEM_LAT setting. The memory
  // returns noise on mem_dout except along the pipeline slot of a real load.
  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int LAT = (g == 0) ? 1 : 3;
    nrisc_mem_port_master_if #(.TAM(TAM)) bus ();
    logic [15:0] mem [256] = '{default: 16'h0000};
    logic [15:0] dly [LAT] = '{default: 16'h0000};
    int nLoads  = 0;
    int nWrites = 0;

    nrisc_mem_port_master #(.TAM(TAM), .Lmem(LMEM), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req_valid = reqValid[g];
    assign bus.req_we    = reqWe[g];
    assign bus.req_addr  = reqAddr[g];
    assign bus.req_wdata = reqWdata[g];
    assign bus.rsp_ready = rspReady[g];
    assign bus.mem_dout  = dly[LAT-1];
    assign reqReady[g]   = bus.req_ready;
    assign rspValid[g]   = bus.rsp_valid;
    assign rspRdata[g]   = bus.rsp_rdata;
    assign rspWe[g]      = bus.rsp_we;
    assign rspErr[g]     = bus.rsp_err;
    assign memAddr[g]    = bus.mem_addr;
    assign memDin[g]     = bus.mem_din;
    assign memWrite[g]   = bus.mem_write;
    assign memLoad[g]    = bus.mem_load;
    assign loadCnt[g]    = nLoads;
    assign writeCnt[g]   = nWrites;

    always @(posedge clk) begin
      if (bus.mem_write) begin
        mem[bus.mem_addr[7:0]] <= bus.mem_din;
        nWrites <= nWrites + 1;
      end
      if (bus.mem_load) nLoads <= nLoads + 1;
      dly[0] <= bus.mem_load ? mem[bus.mem_addr[7:0]] : 16'($urandom);
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(int d);
    checkOutput("rst_req_ready", 32'(reqReady[d]), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rspValid[d]), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rspRdata[d]), 32'd0);
    checkOutput("rst_rsp_we",    32'(rspWe[d]),    32'd0);
    checkOutput("rst_rsp_err",   32'(rspErr[d]),   32'd0);
    checkOutput("rst_mem_addr",  32'(memAddr[d]),  32'd0);
    checkOutput("rst_mem_din",   32'(memDin[d]),   32'd0);
    checkOutput("rst_mem_write", 32'(memWrite[d]), 32'd0);
    checkOutput("rst_mem_load",  32'(memLoad[d]),  32'd0);
  endtask

  // One complete transaction on DUT d, entered and left at posedge+1.
  task automatic applyStimulus(int d, logic we, logic [15:0] addr,
                               logic [15:0] wdata, int hold);
    logic        err;
    logic [15:0] expData;
    logic [15:0] expAddr;
    int          lat;
    int          loads0;
    int          writes0;
`ifdef NRISC_MEM_ADDR_CHECK_EN
    err = (addr[15:8] != 8'h00);
`else
    err = 1'b0;
`endif
    lat     = we ? 1 : 1 + ((d == 0) ? 1 : 3);
    expAddr = {8'h00, addr[7:0]};
    expData = (we || err) ? 16'h0000 : refMem[d][addr[7:0]];
    if (we && !err) refMem[d][addr[7:0]] = wdata;
    loads0  = int'(loadCnt[d]);
    writes0 = int'(writeCnt[d]);

    checkOutput("idle_req_ready", 32'(reqReady[d]), 32'd1);
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    @(posedge clk); #1;
    reqValid[d] = 1'b0;
    reqWe[d]    = 1'($urandom);
    reqAddr[d]  = 16'($urandom);
    reqWdata[d] = 16'($urandom);

    checkOutput("issue_req_ready", 32'(reqReady[d]), 32'd0);
    checkOutput("issue_rsp_valid", 32'(rspValid[d]), 32'd0);
    checkOutput("issue_mem_write", 32'(memWrite[d]), 32'(we && !err));
    checkOutput("issue_mem_load",  32'(memLoad[d]),  32'(!we && !err));
    checkOutput("issue_mem_addr",  32'(memAddr[d]),  32'(expAddr));
    checkOutput("issue_mem_din",   32'(memDin[d]),   32'(wdata));

    for (int c = 1; c < lat; c++) begin
      @(posedge clk); #1;
      checkOutput("wait_rsp_valid", 32'(rspValid[d]), 32'd0);
      checkOutput("wait_req_ready", 32'(reqReady[d]), 32'd0);
      checkOutput("wait_mem_load",  32'(memLoad[d]),  32'd0);
      checkOutput("wait_mem_write", 32'(memWrite[d]), 32'd0);
      checkOutput("wait_mem_addr",  32'(memAddr[d]),  32'(expAddr));
    end

    @(posedge clk); #1;
    checkOutput("rsp_valid",   32'(rspValid[d]), 32'd1);
    checkOutput("rsp_rdata",   32'(rspRdata[d]), 32'(expData));
    checkOutput("rsp_we",      32'(rspWe[d]),    32'(we));
    checkOutput("rsp_err",     32'(rspErr[d]),   32'(err));
    checkOutput("load_pulses", 32'(int'(loadCnt[d]) - loads0),   32'(!we && !err));
    checkOutput("write_pulses",32'(int'(writeCnt[d]) - writes0), 32'(we && !err));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("bp_rsp_valid", 32'(rspValid[d]), 32'd1);
      checkOutput("bp_rsp_rdata", 32'(rspRdata[d]), 32'(expData));
      checkOutput("bp_req_ready", 32'(reqReady[d]), 32'd0);
      checkOutput("bp_mem_write", 32'(memWrite[d]), 32'd0);
      checkOutput("bp_mem_load",  32'(memLoad[d]),  32'd0);
    end

    rspReady[d] = 1'b1;
    @(posedge clk); #1;
    rspReady[d] = 1'b0;
    checkOutput("done_rsp_valid", 32'(rspValid[d]), 32'd0);
    checkOutput("done_req_ready", 32'(reqReady[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) refMem[d][i] = 16'h0000;
    rst      = 1'b1;
    reqValid = '0;
    reqWe    = '0;
    rspReady = '0;
    reqAddr  = '0;
    reqWdata = '0;
    #3;
    checkResetOutputs(0);
    checkResetOutputs(1);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Store then load on the single-cycle port.
    applyStimulus(0, 1'b1, 16'h0012, 16'hBEEF, 0);
    applyStimulus(0, 1'b0, 16'h0012, 16'h0000, 0);

    // Three-cycle latency on the other port.
    applyStimulus(1, 1'b1, 16'h0040, 16'h00A5, 0);
    applyStimulus(1, 1'b0, 16'h0040, 16'h0000, 0);

    // Held response.
    applyStimulus(0, 1'b0, 16'h0012, 16'h0000, 5);

    // Upper address bits: wrap by default, error with the checker enabled.
    applyStimulus(0, 1'b1, 16'h01FF, 16'h1234, 0);
    applyStimulus(0, 1'b0, 16'h00FF, 16'h0000, 0);
    applyStimulus(0, 1'b0, 16'h0100, 16'h0000, 2);
    applyStimulus(1, 1'b0, 16'h0100, 16'h0000, 0);

    // Reset while waiting on load data: response must never appear.
    reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 16'h0012;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkResetOutputs(0);
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_rsp_valid", 32'(rspValid[0]), 32'd0);
      checkOutput("post_rst_req_ready", 32'(reqReady[0]), 32'd1);
    end

    // Reset during ISSUE of a store: write strobe drops, memory untouched.
    begin
      int w0;
      w0 = int'(writeCnt[0]);
      reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 16'h0012; reqWdata[0] = 16'hDEAD;
      @(posedge clk); #1;
      reqValid[0] = 1'b0;
      checkOutput("issue_mem_write_pre", 32'(memWrite[0]), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_mem_write", 32'(memWrite[0]), 32'd0);
      checkResetOutputs(0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_no_write", 32'(int'(writeCnt[0]) - w0), 32'd0);
      checkOutput("rst_idle_rsp_valid", 32'(rspValid[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 16'h0012, 16'h0000, 0);

    // Random mix on both ports.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [15:0] a;
        a = {(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00),
             4'h0, 4'($urandom_range(0, 15))};
        applyStimulus(d, 1'($urandom_range(0, 1)), a, 16'($urandom),
                      int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
